// File: rtl/reception_queue.sv
// Reception desk arrival queue: tokens arriving patients, holds them in FIFO
// order and offers the head patient to the doctor allocator, retrying after a wait.
module reception_queue #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned TOKEN_W      = 8,
  parameter int unsigned RETRY_CYCLES = 15
) (
  input  logic                         clk,
  input  logic                         start,
  input  logic                         arrive,
  input  logic [1:0]                   arrive_query,
  output logic                         arrive_ack,
  output logic                         arrive_drop,
  output logic [TOKEN_W-1:0]           arrive_token,
  output logic                         alloc_req,
  output logic [1:0]                   alloc_query,
  input  logic [1:0]                   alloc_msg,
  output logic                         assign_valid,
  output logic [TOKEN_W-1:0]           assign_token,
  output logic [1:0]                   assign_doctor,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [BW-1:0] RETRY_LOAD = BW'(RETRY_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    BACKOFF
  } state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        count_nxt;
  logic [TOKEN_W-1:0]   tok;
  logic [BW-1:0]        boff;
  logic [TOKEN_W+1:0]   mem [DEPTH];
  logic [1:0]           head_query;
  logic [TOKEN_W-1:0]   head_token;
  logic                 push, pop, load_boff, issue_req;

  // full is the registered flag, so a pop on the same edge cannot make room
  assign push       = arrive & ~full;
  assign head_query = mem[rptr][TOKEN_W+1:TOKEN_W];
  assign head_token = mem[rptr][TOKEN_W-1:0];

  always_ff @(posedge clk or posedge start) begin
    if (start) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_boff = 1'b0;
    case (state)
      IDLE:    if (count != '0) state_nxt = REQ;
      REQ:     state_nxt = RESP;
      RESP: begin
        if (alloc_msg == 2'd1 || alloc_msg == 2'd2) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end else begin
          load_boff = 1'b1;
          state_nxt = BACKOFF;
        end
      end
      BACKOFF: if (boff == '0) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    issue_req = (state_nxt == REQ);

    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {arrive_query, tok};
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      tok           <= TOKEN_W'(1);
      boff          <= '0;
      arrive_ack    <= 1'b0;
      arrive_drop   <= 1'b0;
      arrive_token  <= '0;
      alloc_req     <= 1'b0;
      alloc_query   <= '0;
      assign_valid  <= 1'b0;
      assign_token  <= '0;
      assign_doctor <= '0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);

      if (push) begin
        wptr <= wptr + AW'(1);
        // token 0 is reserved, so the counter wraps back to 1
        tok  <= (tok == '1) ? TOKEN_W'(1) : tok + TOKEN_W'(1);
      end
      if (pop) rptr <= rptr + AW'(1);

      arrive_ack    <= push;
      arrive_drop   <= arrive & full;
      arrive_token  <= push ? tok : '0;

      alloc_req     <= issue_req;
      alloc_query   <= issue_req ? head_query : '0;

      assign_valid  <= pop;
      assign_token  <= pop ? head_token : '0;
      assign_doctor <= pop ? alloc_msg : '0;

      if (load_boff)                          boff <= RETRY_LOAD;
      else if (state == BACKOFF && boff != '0) boff <= boff - BW'(1);
    end
  end

endmodule
